dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter for the single-port data memory. It shares the data memory between the pipeline's MEM stage (`cpu_*`) and an external loader/debug port (`ext_*`) that preloads or inspects data. It sits between the datapath and the data memory. It grants at most one access per cycle and routes each read response back to the requester that issued it. It also stalls the pipeline when the external port wins a cycle.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `STARVE_MAX`, 4, consecutive cycles the external port may be denied before it is forced through (range 1..15)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  pipeline requests access this cycle
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  pipeline address
- `cpu_wdata`  in  DW  pipeline write data
- `cpu_stall`  out  1  pipeline request not serviced this cycle; pipeline must hold it
- `cpu_rvalid`  out  1  `cpu_rdata` valid
- `cpu_rdata`  out  DW  pipeline read data
- `ext_req`  in  1  external port requests access; held until granted
- `ext_we`  in  1  1 = write, 0 = read
- `ext_addr`  in  AW  external address
- `ext_wdata`  in  DW  external write data
- `ext_gnt`  out  1  external request serviced this cycle
- `ext_rvalid`  out  1  `ext_rdata` valid
- `ext_rdata`  out  DW  external read data
- `mem_addr`  out  AW  to data memory address
- `mem_wdata`  out  DW  to data memory write data
- `mem_we`  out  1  to data memory write enable
- `mem_rdata`  in  DW  from data memory; valid one cycle after a read address is presented

## Operation
- Grant decision is combinational each cycle from the requests and the starvation state:
  - `force_ext` = `ext_req` && (`wait_cnt` == `STARVE_MAX`).
  - `ext_gnt` = `ext_req` && (!`cpu_req` || `force_ext`).
  - `cpu_grant` = `cpu_req` && !`ext_gnt`.
  - `cpu_stall` = `cpu_req` && `ext_gnt`.
- Memory mux:
  - Granted requester drives `mem_addr`, `mem_wdata` and `mem_we`.
  - With no grant: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Starvation counter `wait_cnt` (4 bits):
  - Increments on each cycle with `ext_req` && !`ext_gnt`, saturating at `STARVE_MAX`.
  - Clears on `ext_gnt` or on !`ext_req`.
- Response routing uses a registered owner tag, `rd_owner` ∈ {NONE, CPU, EXT}:
  - Set each cycle to the granted requester when the granted access is a read; otherwise NONE.
  - Next cycle: `cpu_rvalid` = (`rd_owner` == CPU) and `ext_rvalid` = (`rd_owner` == EXT).
  - `cpu_rdata` and `ext_rdata` pass `mem_rdata` through when their rvalid is set, and are 0 otherwise.
- Writes produce no response.
- Back-to-back reads are fully pipelined: one grant and one response per cycle.

## Timing
- Grant is zero-cycle: the access occurs in the same cycle as `ext_gnt` / !`cpu_stall`.
- Read latency is exactly 1 cycle from grant to rvalid, for both ports.
- Reset (`rst` low, asynchronous):
  - `wait_cnt` = 0 and `rd_owner` = NONE.
  - `cpu_rvalid` = `ext_rvalid` = 0, and both rdata = 0.
  - The combinational outputs follow their inputs; with no requests, `ext_gnt` = `cpu_stall` = `mem_we` = 0.
- Reset during an in-flight read drops the response: no rvalid after release.
- Simultaneous requests without force: CPU wins, and the external port stalls with `wait_cnt` incrementing.
- Forced cycle: EXT wins, `cpu_stall` = 1, and `wait_cnt` returns to 0. With both requests continuous, EXT therefore wins 1 of every `STARVE_MAX`+1 cycles.
- Dropping `ext_req` before grant is a protocol violation; the arbiter simply clears `wait_cnt`.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: starvation counter and forced grant as described.
- Not defined:
  - Strict CPU priority; `wait_cnt` and `force_ext` are removed (`force_ext` ≡ 0).
  - The external port is granted only in cycles with !`cpu_req`.
  - `STARVE_MAX` is ignored.

## Test plan
- Reset then idle, no requests -> all outputs 0, and no rvalid for 5 cycles.
- CPU read of addr 0x0010 with memory holding 0xBEEF there, `ext_req` = 0 -> `cpu_stall` = 0, `mem_addr` = 0x0010; next cycle `cpu_rvalid` = 1, `cpu_rdata` = 0xBEEF, `ext_rvalid` = 0.
- EXT write 0x1234 to 0x0020 while CPU idle -> same-cycle `ext_gnt` = 1, `mem_we` = 1, `mem_wdata` = 0x1234; a subsequent CPU read of 0x0020 returns 0x1234.
- `cpu_req` and `ext_req` held high from cycle 0, `STARVE_MAX` = 4, macro defined -> CPU granted cycles 0–3; cycle 4 `ext_gnt` = 1 and `cpu_stall` = 1; CPU cycle 5; EXT again at cycle 9.
- Same stimulus with macro undefined -> `ext_gnt` never asserts; `cpu_stall` stays 0 for 20 cycles.
- Alternating CPU read (0x0001) and forced EXT read (0x0002) back-to-back -> each rvalid pulses only on its own port, one cycle after its grant, with the matching data. Asserting `rst` low in the cycle after a grant -> no rvalid appears.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage
// (cpu_*) and an external loader/debug port (ext_*).
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_stall, cpu_rvalid, cpu_rdata
//   ext_req/we/addr/wdata -> ext_gnt, ext_rvalid, ext_rdata
//   mem_addr/wdata/we     -> memory; mem_rdata <- memory (1-cycle read)
//
// Config macro: DMEM_ARB_STARVE_EN enables the starvation counter that
// forces an external grant after STARVE_MAX denied cycles. Without it
// the CPU has strict priority.
module dmem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    owner_t rd_owner;
    logic   force_ext;
    logic   cpu_grant;

`ifdef DMEM_ARB_STARVE_EN
    logic [3:0] wait_cnt;

    assign force_ext = ext_req && (wait_cnt == SMAX);

    // Counts consecutive denied cycles of a pending external request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (!ext_req || ext_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != SMAX) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    logic unused_cfg;

    assign force_ext  = 1'b0;
    assign unused_cfg = ^SMAX;
`endif

    assign ext_gnt   = ext_req && (!cpu_req || force_ext);
    assign cpu_grant = cpu_req && !ext_gnt;
    assign cpu_stall = cpu_req && ext_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        unique case (1'b1)
            ext_gnt: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_we    = ext_we;
            end
            cpu_grant: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            default: ;
        endcase
    end

    // Remembers who issued the read whose data returns next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_owner <= OWN_NONE;
        end else if (ext_gnt && !ext_we) begin
            rd_owner <= OWN_EXT;
        end else if (cpu_grant && !cpu_we) begin
            rd_owner <= OWN_CPU;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign ext_rvalid = (rd_owner == OWN_EXT);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule
